// File: rtl/div_fxp_pkg.sv
// Shared definitions for the sequential fixed-point divider.
//   state_e          : controller states
//   iter_count()     : number of RUN cycles for a given width/fraction/unroll
//   cfg_ok()         : legality of a parameter set, checked at elaboration
//   sat_max/sat_min(): saturation bounds of a w-bit signed word (w <= 64)
package div_fxp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin,
        StDone
    } state_e;

    function automatic int unsigned iter_count(int unsigned w, int unsigned frac,
                                               int unsigned unroll);
        return (w + frac) / unroll;
    endfunction

    // UNROLL must split W+FRAC evenly and leave at least two RUN cycles so the
    // numerator/quotient shift register always has a non-empty carry-over part.
    function automatic bit cfg_ok(int unsigned w, int unsigned frac, int unsigned unroll);
        return (w >= 2) && (w <= 64) && (frac > 0) && (frac < w) && (unroll > 0) &&
               (unroll < w + frac) && (((w + frac) % unroll) == 0);
    endfunction

    function automatic logic [63:0] sat_max(int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Two's complement minimum; the low w bits hold the pattern 100..0.
    function automatic logic [63:0] sat_min(int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_fxp_step.sv
// Combinational chain of UNROLL restoring division steps, MSB first.
//   rem_i : partial remainder entering the chain (W+1 bits)
//   num_i : next UNROLL numerator bits, bit UNROLL-1 consumed first
//   div_i : divisor magnitude (W+1 bits)
//   rem_o : partial remainder after UNROLL steps
//   q_o   : UNROLL quotient bits, bit UNROLL-1 produced first
module div_fxp_step #(
    parameter int unsigned W      = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic [W:0]        rem_i,
    input  logic [UNROLL-1:0] num_i,
    input  logic [W:0]        div_i,
    output logic [W:0]        rem_o,
    output logic [UNROLL-1:0] q_o
);

    logic [W:0] rem_chain [UNROLL+1];

    assign rem_chain[0] = rem_i;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        logic [W+1:0] trial;
        logic [W:0]   diff;
        logic         ge;

        assign trial = {rem_chain[i], num_i[UNROLL-1-i]};
        // Only the low W+1 bits of the difference are kept; when ge is set the
        // true difference is below the divisor and fits.
        assign diff  = trial[W:0] - div_i;
        assign ge    = (trial >= {1'b0, div_i});

        assign q_o[UNROLL-1-i] = ge;
        assign rem_chain[i+1]  = ge ? diff : trial[W:0];
    end

    assign rem_o = rem_chain[UNROLL];

endmodule

// File: rtl/div_fxp_seq.sv
// Multi-cycle signed fixed-point divider: q = (a << FRAC) / b, truncated toward
// zero and saturated to W bits, with a valid/ready handshake on both sides.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  : operand handshake (in_ready_o high only in IDLE)
//   in_a_i, in_b_i, in_tag_i : dividend, divisor (signed Q format), opaque tag
//   out_valid_o / out_ready_i: result handshake (out_valid_o high only in DONE)
//   out_q_o, out_tag_o       : saturated quotient and its tag
//   out_dz_o, out_ovf_o      : divisor was zero / quotient saturated by magnitude
module div_fxp_seq
    import div_fxp_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned FRAC   = 24,
    parameter int unsigned UNROLL = 1,
    parameter int unsigned TAG_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_a_i,
    input  logic [W-1:0]     in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_q_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_dz_o,
    output logic             out_ovf_o
);

    localparam int unsigned QW   = W + FRAC + 1;  // numerator / full quotient width
    localparam int unsigned Iter = iter_count(W, FRAC, UNROLL);
    localparam int unsigned CntW = $clog2(Iter + 1);

    localparam logic [63:0]  SatMax64 = sat_max(W);
    localparam logic [63:0]  SatMin64 = sat_min(W);
    localparam logic [W-1:0] SatMax   = SatMax64[W-1:0];
    localparam logic [W-1:0] SatMin   = SatMin64[W-1:0];

    if (!cfg_ok(W, FRAC, UNROLL)) begin : g_cfg_check
        $error("div_fxp_seq: illegal W/FRAC/UNROLL combination");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    // Numerator bits shift out at the top while quotient bits shift in at the
    // bottom; after Iter cycles the register holds the full quotient.
    logic [QW-1:0]     num_q, num_d;
    logic [W:0]        rem_q, rem_d;
    logic [W:0]        div_q, div_d;
    logic              neg_q, neg_d;
    logic              a_neg_q, a_neg_d;
    logic              dz_q, dz_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [W-1:0]      out_q_q, out_q_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_dz_q, out_dz_d;
    logic              out_ovf_q, out_ovf_d;

    // Operand magnitudes in W+1 bits so that -2^(W-1) is representable.
    logic [W:0] a_ext, b_ext, abs_a, abs_b;

    assign a_ext = {in_a_i[W-1], in_a_i};
    assign b_ext = {in_b_i[W-1], in_b_i};
    assign abs_a = in_a_i[W-1] ? -a_ext : a_ext;
    assign abs_b = in_b_i[W-1] ? -b_ext : b_ext;

    logic [W:0]        step_rem;
    logic [UNROLL-1:0] step_q;

    div_fxp_step #(
        .W      (W),
        .UNROLL (UNROLL)
    ) u_step (
        .rem_i (rem_q),
        .num_i (num_q[QW-2 -: UNROLL]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // Magnitude classification of the finished quotient.
    logic pos_big, neg_hi, low_nz, neg_big, neg_exact;

    assign pos_big   = |num_q[QW-1:W-1];
    assign neg_hi    = |num_q[QW-1:W];
    assign low_nz    = |num_q[W-2:0];
    assign neg_big   = neg_hi | (num_q[W-1] & low_nz);
    assign neg_exact = !neg_hi & num_q[W-1] & !low_nz;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        rem_d     = rem_q;
        div_d     = div_q;
        neg_d     = neg_q;
        a_neg_d   = a_neg_q;
        dz_d      = dz_q;
        tag_d     = tag_q;
        out_q_d   = out_q_q;
        out_tag_d = out_tag_q;
        out_dz_d  = out_dz_q;
        out_ovf_d = out_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    neg_d   = in_a_i[W-1] ^ in_b_i[W-1];
                    a_neg_d = in_a_i[W-1];
                    dz_d    = (in_b_i == '0);
                    div_d   = abs_b;
                    tag_d   = in_tag_i;
                    num_d   = {abs_a, {FRAC{1'b0}}};
                    rem_d   = '0;
                    cnt_d   = CntW'(Iter);
                    state_d = StRun;
                end
            end
            StRun: begin
                rem_d = step_rem;
                num_d = {num_q[QW-1-UNROLL:0], step_q};
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                out_tag_d = tag_q;
                out_dz_d  = dz_q;
                out_ovf_d = 1'b0;
                if (dz_q) begin
                    out_q_d = a_neg_q ? SatMin : SatMax;
                end else if (!neg_q) begin
                    out_q_d   = pos_big ? SatMax : num_q[W-1:0];
                    out_ovf_d = pos_big;
                end else if (neg_big) begin
                    out_q_d   = SatMin;
                    out_ovf_d = 1'b1;
                end else if (neg_exact) begin
                    out_q_d = SatMin;
                end else begin
                    out_q_d = -num_q[W-1:0];
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            num_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            neg_q     <= 1'b0;
            a_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
            tag_q     <= '0;
            out_q_q   <= '0;
            out_tag_q <= '0;
            out_dz_q  <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            a_neg_q   <= a_neg_d;
            dz_q      <= dz_d;
            tag_q     <= tag_d;
            out_q_q   <= out_q_d;
            out_tag_q <= out_tag_d;
            out_dz_q  <= out_dz_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign out_q_o     = out_q_q;
    assign out_tag_o   = out_tag_q;
    assign out_dz_o    = out_dz_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_div_fxp_seq.sv
// Bench for div_fxp_seq: four instances (default, UNROLL=4, UNROLL=8, W=16/FRAC=8)
// share handshake strobes and are compared against a 64-bit arithmetic model.
module tb_div_fxp_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [7:0]  tag = '0;

    logic [3:0]  rdy, vld, dzs, ovfs;
    logic [7:0]  otag [4];
    logic [31:0] q0, q1, q2;
    logic [15:0] q3;

    int errors = 0;
    int checks = 0;

    // Results of the last transaction
    logic [31:0] rq [4];
    logic [7:0]  rtag [4];
    logic [3:0]  rdz, rovf;
    int          lat [4];
    bit          timed_out;
    int          exp_lat [4] = '{57, 15, 8, 25};

    div_fxp_seq u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
        .in_a_i(a32), .in_b_i(b32), .in_tag_i(tag), .out_valid_o(vld[0]),
        .out_ready_i(out_ready), .out_q_o(q0), .out_tag_o(otag[0]), .out_dz_o(dzs[0]),
        .out_ovf_o(ovfs[0])
    );

    div_fxp_seq #(.UNROLL(4)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
        .in_a_i(a32), .in_b_i(b32), .in_tag_i(tag), .out_valid_o(vld[1]),
        .out_ready_i(out_ready), .out_q_o(q1), .out_tag_o(otag[1]), .out_dz_o(dzs[1]),
        .out_ovf_o(ovfs[1])
    );

    div_fxp_seq #(.UNROLL(8)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
        .in_a_i(a32), .in_b_i(b32), .in_tag_i(tag), .out_valid_o(vld[2]),
        .out_ready_i(out_ready), .out_q_o(q2), .out_tag_o(otag[2]), .out_dz_o(dzs[2]),
        .out_ovf_o(ovfs[2])
    );

    div_fxp_seq #(.W(16), .FRAC(8), .UNROLL(1)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[3]),
        .in_a_i(a16), .in_b_i(b16), .in_tag_i(tag), .out_valid_o(vld[3]),
        .out_ready_i(out_ready), .out_q_o(q3), .out_tag_o(otag[3]), .out_dz_o(dzs[3]),
        .out_ovf_o(ovfs[3])
    );

    // Reference: {dz, ovf, q} from exact integer arithmetic.
    function automatic logic [65:0] model(input longint a, input longint b, input int w,
                                          input int frac);
        longint mx, mn, q;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        if (b == 0) return {1'b1, 1'b0, (a < 0) ? mn : mx};
        q = (a * (longint'(1) <<< frac)) / b;
        if (q > mx) return {1'b0, 1'b1, mx};
        if (q < mn) return {1'b0, 1'b1, mn};
        return {1'b0, 1'b0, q};
    endfunction

    // Issue one operation to all instances, wait for every result, consume it.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic [15:0] as,
                          input logic [15:0] bs, input logic [7:0] t);
        int n;
        a32 = a; b32 = b; a16 = as; b16 = bs; tag = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a32 = $urandom; b32 = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
        tag = 8'($urandom);
        for (int k = 0; k < 4; k++) lat[k] = 0;
        n = 0;
        while (vld != 4'hF && n < 200) begin
            @(posedge clk); #1;
            n++;
            for (int k = 0; k < 4; k++) if (vld[k] && lat[k] == 0) lat[k] = n;
        end
        timed_out = (vld != 4'hF);
        rq[0] = q0; rq[1] = q1; rq[2] = q2; rq[3] = {16'h0, q3};
        for (int k = 0; k < 4; k++) rtag[k] = otag[k];
        rdz = dzs; rovf = ovfs;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (rdy !== 4'hF || vld !== 4'h0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1111/0000", rdy, vld);
        end
        checks++;
        if (q0 !== 32'h0 || otag[0] !== 8'h0 || dzs !== 4'h0 || ovfs !== 4'h0) begin
            errors++;
            $display("FAIL reset_out: q=%h tag=%h dz=%b ovf=%b want zeros", q0, otag[0], dzs,
                     ovfs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rdy !== 4'hF || vld !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b valid=%b want 1111/0000", rdy, vld);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dz;
        logic        ovf;
    } vec_t;

    task automatic test_directed();
        vec_t tbl [9];
        logic [7:0] t;
        tbl = '{
            '{32'h01000000, 32'h02000000, 32'h00800000, 1'b0, 1'b0},
            '{32'hFD000000, 32'h00800000, 32'hFA000000, 1'b0, 1'b0},
            '{32'h01000000, 32'h03000000, 32'h00555555, 1'b0, 1'b0},
            '{32'hFF000000, 32'h03000000, 32'hFFAAAAAB, 1'b0, 1'b0},
            '{32'h7F000000, 32'h00100000, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{32'h80000000, 32'h01000000, 32'h80000000, 1'b0, 1'b0},
            '{32'h80000000, 32'hFF000000, 32'h7FFFFFFF, 1'b0, 1'b1},
            '{32'hFF000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0},
            '{32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            t = 8'(8'h30 + i);
            do_txn(tbl[i].a, tbl[i].b, 16'h0100, 16'h0300, t);
            checks++;
            if (timed_out) begin
                errors++;
                $display("FAIL dir_timeout[%0d]: valid=%b want 1111", i, vld);
            end
            checks++;
            if (rq[0] !== tbl[i].q) begin
                errors++;
                $display("FAIL dir_q[%0d]: got %h want %h", i, rq[0], tbl[i].q);
            end
            checks++;
            if (rdz[0] !== tbl[i].dz || rovf[0] !== tbl[i].ovf) begin
                errors++;
                $display("FAIL dir_flags[%0d]: dz=%b ovf=%b want dz=%b ovf=%b", i, rdz[0],
                         rovf[0], tbl[i].dz, tbl[i].ovf);
            end
            checks++;
            if (lat[0] != 57) begin
                errors++;
                $display("FAIL dir_latency[%0d]: got %0d want 57", i, lat[0]);
            end
            checks++;
            if (rtag[0] !== t) begin
                errors++;
                $display("FAIL dir_tag[%0d]: got %h want %h", i, rtag[0], t);
            end
        end
    endtask

    function automatic logic [31:0] rand_div32();
        int m;
        logic [31:0] v;
        m = $urandom_range(0, 9);
        if (m == 0) return 32'h0;
        if (m <= 3) begin
            v = 32'($urandom_range(1, 255));
            return ($urandom_range(0, 1) == 1) ? -v : v;
        end
        if (m == 4) return ($urandom_range(0, 1) == 1) ? 32'hFF000000 : 32'h01000000;
        return $urandom;
    endfunction

    function automatic logic [15:0] rand_div16();
        int m;
        logic [15:0] v;
        m = $urandom_range(0, 9);
        if (m == 0) return 16'h0;
        if (m <= 3) begin
            v = 16'($urandom_range(1, 15));
            return ($urandom_range(0, 1) == 1) ? -v : v;
        end
        if (m == 4) return ($urandom_range(0, 1) == 1) ? 16'hFF00 : 16'h0100;
        return 16'($urandom);
    endfunction

    task automatic test_random(input int count);
        logic [31:0] a, b;
        logic [15:0] as, bs;
        logic [7:0]  t;
        logic [65:0] e32, e16;
        for (int i = 0; i < count; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
            as = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            b  = rand_div32();
            bs = rand_div16();
            t  = 8'($urandom);
            e32 = model(longint'($signed(a)), longint'($signed(b)), 32, 24);
            e16 = model(longint'($signed(as)), longint'($signed(bs)), 16, 8);
            do_txn(a, b, as, bs, t);
            checks++;
            if (timed_out) begin
                errors++;
                $display("FAIL rnd_timeout[%0d]: valid=%b want 1111", i, vld);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rq[k] !== e32[31:0] || rdz[k] !== e32[65] || rovf[k] !== e32[64]) begin
                    errors++;
                    $display("FAIL rnd_q32[%0d] dut%0d a=%h b=%h: got q=%h dz=%b ovf=%b want %h/%b/%b",
                             i, k, a, b, rq[k], rdz[k], rovf[k], e32[31:0], e32[65], e32[64]);
                end
            end
            checks++;
            if (rq[3][15:0] !== e16[15:0] || rdz[3] !== e16[65] || rovf[3] !== e16[64]) begin
                errors++;
                $display("FAIL rnd_q16[%0d] a=%h b=%h: got q=%h dz=%b ovf=%b want %h/%b/%b", i,
                         as, bs, rq[3][15:0], rdz[3], rovf[3], e16[15:0], e16[65], e16[64]);
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (lat[k] != exp_lat[k] || rtag[k] !== t) begin
                    errors++;
                    $display("FAIL rnd_lat_tag[%0d] dut%0d: lat=%0d tag=%h want %0d/%h", i, k,
                             lat[k], rtag[k], exp_lat[k], t);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        a32 = 32'h01000000; b32 = 32'h02000000; a16 = 16'h0100; b16 = 16'h0200;
        tag = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (vld != 4'hF && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (vld !== 4'hF) begin
            errors++;
            $display("FAIL bp_timeout: valid=%b want 1111", vld);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            a32 = $urandom; b32 = $urandom; tag = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (q0 !== 32'h00800000 || otag[0] !== 8'hA5 || dzs[0] !== 1'b0 ||
                ovfs[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: q=%h tag=%h dz=%b ovf=%b want 00800000/a5/0/0", c,
                         q0, otag[0], dzs[0], ovfs[0]);
            end
            checks++;
            if (rdy !== 4'h0 || vld !== 4'hF) begin
                errors++;
                $display("FAIL bp_hs[%0d]: ready=%b valid=%b want 0000/1111", c, rdy, vld);
            end
        end
        // in_valid stays high across the consuming edge; it must not be taken.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (vld !== 4'h0 || rdy !== 4'hF) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b want 0000/1111", vld, rdy);
        end
        @(posedge clk); #1;
        checks++;
        if (rdy !== 4'hF || vld !== 4'h0) begin
            errors++;
            $display("FAIL bp_idle: ready=%b valid=%b want 1111/0000", rdy, vld);
        end
    endtask

    task automatic test_reset_mid_run();
        int spurious;
        logic [65:0] e32;
        a32 = 32'h05000000; b32 = 32'h00300000; a16 = 16'h0500; b16 = 16'h0030;
        tag = 8'h5A;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (vld !== 4'h0 || rdy !== 4'hF) begin
            errors++;
            $display("FAIL mid_rst_hs: valid=%b ready=%b want 0000/1111", vld, rdy);
        end
        checks++;
        if (q0 !== 32'h0 || otag[0] !== 8'h0 || q3 !== 16'h0 || dzs !== 4'h0 ||
            ovfs !== 4'h0) begin
            errors++;
            $display("FAIL mid_rst_out: q0=%h tag=%h q3=%h dz=%b ovf=%b want zeros", q0,
                     otag[0], q3, dzs, ovfs);
        end
        #8;
        rst_n = 1'b1;
        spurious = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (vld !== 4'h0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL mid_rst_spurious: %0d cycles with valid, want 0", spurious);
        end
        e32 = model(longint'(32'sh01000000), longint'(32'sh03000000), 32, 24);
        do_txn(32'h01000000, 32'h03000000, 16'hFF00, 16'h0300, 8'h77);
        checks++;
        if (timed_out || rq[0] !== 32'h00555555 || rq[2] !== e32[31:0] ||
            rq[3][15:0] !== 16'hFFAB || rtag[0] !== 8'h77) begin
            errors++;
            $display("FAIL mid_rst_after: q0=%h q2=%h q3=%h tag=%h want 00555555/%h/ffab/77",
                     rq[0], rq[2], rq[3][15:0], rtag[0], e32[31:0]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random(40);
        test_backpressure();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
